ntt_stage_sequencer: RTL
========================

// Module: ntt_stage_sequencer
// PURPOSE
//  Control source for one NTT on the core array: runs the stage loop and generates core-memory read addresses.
//  Drives the coefficient router with stage (log_m, log_t) and write-back addresses (address_0/1), delayed to
//  align with read data. Issues loop write enables per compute stage, then one output pass with log_t = 4'hF.
// PARAMETERS
//  LOG_CORE_COUNT  5   log2 of core count (32 cores)
//  LOG_N           12  log2 of polynomial length (4096)
//  READ_LAT        6   cycles from rd_addr issue to router input valid (memory + butterfly pipeline)
//  ADDR_W          9   core memory address width; bit ADDR_W-1 is the ping-pong bank select
// PORTS
//  clk          in   1       clock; all logic on posedge
//  rst_n        in   1       synchronous, active-low reset
//  start        in   1       request one full NTT; sampled only in IDLE
//  busy         out  1       high from the cycle after start is accepted until done
//  done         out  1       one-cycle pulse when the output pass has fully drained
//  rd_en        out  1       core-memory read enable, broadcast to all cores
//  rd_addr      out  ADDR_W  core-memory read address = {rd_bank, zeros, word}
//  log_m        out  4       stage index to router, aligned with router input data
//  log_t        out  4       LOG_N-1-log_m in compute stages; 4'hF in the output pass
//  address_0    out  ADDR_W  write-back address to router = {~rd_bank, zeros, word}, aligned with data
//  address_1    out  ADDR_W  identical to address_0 (router applies per-phase offsets)
//  wr_en        out  1       loop write enable, aligned with router output (READ_LAT+1 after rd_en)
//  out_valid    out  1       output-pass data valid, aligned with router output
// BEHAVIOUR
//  WORDS = 2^(LOG_N-LOG_CORE_COUNT-2) = 32 reads per pass; stages s = 0..LOG_N-1, then one output pass.
//  FSM: IDLE -> ISSUE -> DRAIN -> (ISSUE next stage | OUTPUT) ; OUTPUT -> ODRAIN -> IDLE.
//   IDLE:   start=1 -> ISSUE, s=0, word=0, rd_bank=0, busy=1 next cycle.
//   ISSUE:  rd_en=1 each cycle, word 0..WORDS-1; after word WORDS-1 -> DRAIN.
//   DRAIN:  READ_LAT+1 cycles, no reads (avoids RAW across stages); then s++, rd_bank toggles;
//           s==LOG_N -> OUTPUT, else ISSUE.
//   OUTPUT: like ISSUE, with log_t=4'hF, log_m=LOG_N, final bank; -> ODRAIN.
//   ODRAIN: READ_LAT+1 cycles; last cycle registers done=1, busy=0 next; -> IDLE.
//  Pass length WORDS+READ_LAT+1 = 39; total LOG_N+1 = 13 passes = 507 cycles.
//  Alignment: log_m/log_t/address_0/1 equal issue-time values delayed READ_LAT cycles.
//   wr_en delayed READ_LAT+1 (compute passes only); out_valid delayed READ_LAT+1 (output pass only).
//  Delayed outputs hold last value when not valid; only valids/enables are qualified.
//  Reset (any state, mid-NTT included): state=IDLE; busy=done=rd_en=wr_en=out_valid=0;
//   rd_addr=address_0=address_1=0; log_m=0; log_t=0; all delay-line valids cleared (no stray writes).
//  start while busy is ignored; start in the done cycle is ignored (FSM not yet IDLE).
//  No backpressure: once accepted the NTT runs to completion at fixed timing.
// STRUCTURE
//  ntt_pkg: LOG_N, LOG_CORE_COUNT, COEFF_W=30, ADDR_W, LOG_T_OUTPUT=4'hF, seq_state_t enum
//   (IDLE, ISSUE, DRAIN, OUTPUT, ODRAIN).
//  Sub-module ctrl_delay #(WIDTH, DEPTH): reset-clearable shift register.
//   One instance carries {log_m, log_t, address, is_output, valid} READ_LAT stages.
//   A final register stage produces wr_en/out_valid.
// TESTING
//  1 Reset then start pulse -> rd_en high cycles 1..32 after accept; rd_addr 0x000..0x01F; done at cycle 507.
//  2 Stage 0: log_m=0, log_t=11, address_0 0x100..0x11F 6 cycles after reads;
//    wr_en high 7 cycles after rd_en, for 32 cycles.
//  3 Stage 1: rd_addr 0x100..0x11F, address_0 0x000..0x01F, log_t=10; 7-cycle rd_en gap between stages.
//  4 Output pass: log_t=4'hF, log_m=12; out_valid 32 cycles; wr_en never high in that pass.
//  5 rst_n low at cycle 200 -> next cycle all outputs 0, IDLE; no wr_en after; a new start runs a clean NTT.
//  6 start held high continuously -> back-to-back NTTs, one idle cycle between done and next rd_en;
//    start during busy is ignored.

Source files
------------

// File: rtl/ntt_pkg.sv
// Purpose : shared constants and the sequencer state type for the NTT core array control.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package ntt_pkg;

    localparam int LOG_CORE_COUNT = 5;     // 32 cores
    localparam int LOG_N          = 12;    // 4096-point polynomial
    localparam int COEFF_W        = 30;    // coefficient width carried by the router
    localparam int ADDR_W         = 9;     // core memory address; MSB is the ping-pong bank
    localparam int READ_LAT       = 6;     // rd_addr issue to router input valid

    // log_t code that tells the router this pass is the final output pass.
    localparam logic [3:0] LOG_T_OUTPUT = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        OUTPUT,
        ODRAIN
    } seq_state_t;

endpackage

// File: rtl/ctrl_delay.sv
// Purpose : reset-clearable valid-qualified shift register for control fields.
// Latency : DEPTH cycles from src to dst.
// Backpressure: none; shifts every cycle.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset (clears every stage)
//   src_valid/src_data  entry into stage 0
//   dst_valid/dst_data  output of stage DEPTH-1
module ctrl_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             dst_valid,
    output logic [WIDTH-1:0] dst_data
);

    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] dat_q [DEPTH];

    // Payload only advances alongside a valid, so every stage (and therefore
    // the output) keeps the last valid payload while bubbles pass through.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= src_valid;
            if (src_valid) begin
                dat_q[0] <= src_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign dst_valid = vld_q[DEPTH-1];
    assign dst_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/ntt_stage_sequencer.sv
// Purpose : runs the NTT stage loop, issues core-memory reads, and feeds the router
//           stage/write-back control aligned with read data, then one output pass.
// Latency : reads start 1 cycle after start is accepted; router control READ_LAT after
//           each read, wr_en/out_valid READ_LAT+1 after; done 13 passes x 39 cycles later.
// Backpressure: none; once accepted the NTT runs at fixed timing, start ignored while busy.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   start                  request one NTT (sampled only in IDLE)
//   busy, done             busy while running; done pulses in the last drain cycle
//   rd_en, rd_addr         broadcast core-memory read {bank, zeros, word}
//   log_m, log_t           stage control to router, aligned with router input data
//   address_0, address_1   write-back address {~bank, zeros, word}, aligned with data
//   wr_en, out_valid       loop write enable / output-pass valid, aligned with router output
module ntt_stage_sequencer #(
    parameter int LOG_CORE_COUNT = ntt_pkg::LOG_CORE_COUNT,
    parameter int LOG_N          = ntt_pkg::LOG_N,
    parameter int READ_LAT       = ntt_pkg::READ_LAT,
    parameter int ADDR_W         = ntt_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        log_m,
    output logic [3:0]        log_t,
    output logic [ADDR_W-1:0] address_0,
    output logic [ADDR_W-1:0] address_1,
    output logic              wr_en,
    output logic              out_valid
);

    import ntt_pkg::*;

    localparam int WORD_W = LOG_N - LOG_CORE_COUNT - 2;
    localparam int CNT_W  = $clog2(READ_LAT + 1);

    localparam logic [WORD_W-1:0] WORD_LAST   = {WORD_W{1'b1}};
    localparam logic [CNT_W-1:0]  DRAIN_LAST  = CNT_W'(READ_LAT);
    localparam logic [3:0]        STAGE_LAST  = 4'(LOG_N - 1);
    localparam logic [3:0]        LOG_T_FIRST = 4'(LOG_N - 1);

    typedef struct packed {
        logic [3:0]        log_m;
        logic [3:0]        log_t;
        logic [ADDR_W-1:0] address;
        logic              is_output;
    } ctrl_t;

    function automatic logic [ADDR_W-1:0] bank_addr(input logic bank, input logic [WORD_W-1:0] w);
        bank_addr = ADDR_W'(w) | (ADDR_W'(bank) << (ADDR_W - 1));
    endfunction

    seq_state_t        state, state_nxt;
    logic [3:0]        stage;
    logic [WORD_W-1:0] word;
    logic [CNT_W-1:0]  drain_cnt;
    logic              rd_bank;
    logic              drain_last;
    logic              issue;
    logic              done_now;

    ctrl_t             issue_ctrl;
    ctrl_t             dly_ctrl;
    logic              dly_vld;
    logic              wr_en_q;
    logic              out_valid_q;

    assign drain_last = (drain_cnt == DRAIN_LAST);

    // ---------------- state register and counters ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            stage     <= '0;
            word      <= '0;
            drain_cnt <= '0;
            rd_bank   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        stage     <= '0;
                        word      <= '0;
                        drain_cnt <= '0;
                        rd_bank   <= 1'b0;
                    end
                end
                ISSUE, OUTPUT: begin
                    // WORDS is a power of two, so the counter wraps to 0 for the next pass.
                    word <= word + 1'b1;
                end
                DRAIN: begin
                    if (drain_last) begin
                        drain_cnt <= '0;
                        stage     <= stage + 1'b1;
                        // Next stage reads what this stage wrote.
                        rd_bank   <= ~rd_bank;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                ODRAIN: begin
                    if (drain_last) begin
                        drain_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------- next state / issue decode ----------------
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done_now  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                issue = 1'b1;
                if (word == WORD_LAST) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // The drain covers the full read-to-write latency so the next
                // stage never reads a word before its last write has landed.
                if (drain_last) begin
                    state_nxt = (stage == STAGE_LAST) ? OUTPUT : ISSUE;
                end
            end
            OUTPUT: begin
                issue = 1'b1;
                if (word == WORD_LAST) begin
                    state_nxt = ODRAIN;
                end
            end
            ODRAIN: begin
                if (drain_last) begin
                    done_now  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---------------- router control, captured at issue time ----------------
    assign issue_ctrl.log_m     = stage;
    assign issue_ctrl.is_output = (state == OUTPUT);
    assign issue_ctrl.log_t     = issue_ctrl.is_output ? LOG_T_OUTPUT : (LOG_T_FIRST - stage);
    assign issue_ctrl.address   = bank_addr(~rd_bank, word);

    ctrl_delay #(
        .WIDTH ($bits(ctrl_t)),
        .DEPTH (READ_LAT)
    ) u_ctrl_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_valid (issue),
        .src_data  (issue_ctrl),
        .dst_valid (dly_vld),
        .dst_data  (dly_ctrl)
    );

    // One more stage to line the enables up with the router output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            wr_en_q     <= dly_vld & ~dly_ctrl.is_output;
            out_valid_q <= dly_vld &  dly_ctrl.is_output;
        end
    end

    // ---------------- outputs ----------------
    assign busy      = (state != IDLE);
    assign done      = done_now;
    assign rd_en     = issue;
    assign rd_addr   = bank_addr(rd_bank, word);
    assign log_m     = dly_ctrl.log_m;
    assign log_t     = dly_ctrl.log_t;
    assign address_0 = dly_ctrl.address;
    assign address_1 = dly_ctrl.address;
    assign wr_en     = wr_en_q;
    assign out_valid = out_valid_q;

endmodule
